// File: rtl/button_parser_if.sv
// Button channel bundle: raw levels in, press pulses and debounced levels out.
// The master side is the button source and the slave side is the parser.
interface button_parser_if #(
  parameter int WIDTH = 4
) ();
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] level;

  modport master (output in, input out, input level);
  modport slave  (input in, output out, output level);
endinterface

// File: rtl/button_parser.sv
// Push-button conditioner: 2-flop sync, shared sample tick, saturating debounce, rising-edge pulse.
// Optional auto-repeat while held is enabled by defining BUTTON_PARSER_REPEAT_EN.
module button_parser #(
  parameter int WIDTH          = 4,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int PULSE_CNT_MAX  = 200,
  parameter int REPEAT_TICKS   = 500
) (
  input logic            clk,
  input logic            rst_n,
  button_parser_if.slave bus
);

  localparam int SCW = $clog2(SAMPLE_CNT_MAX);
  localparam int SW  = $clog2(PULSE_CNT_MAX + 1);

  if (SAMPLE_CNT_MAX < 2 || PULSE_CNT_MAX < 1 || REPEAT_TICKS < 1) begin : g_bad_params
    $error("button_parser: parameter out of range");
  end

  logic [SCW-1:0]   sample_cnt;
  logic             tick;
  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync;
  logic [SW-1:0]    sat_cnt [WIDTH];
  logic [WIDTH-1:0] level_w;
  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync    <= '0;
    end else begin
      sync_q1 <= bus.in;
      sync    <= sync_q1;
    end
  end

  assign tick = (sample_cnt == SCW'(SAMPLE_CNT_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sample_cnt <= '0;
    else if (tick)
      sample_cnt <= '0;
    else
      sample_cnt <= sample_cnt + SCW'(1);
  end

  // A low sample clears immediately; a press must survive PULSE_CNT_MAX ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) sat_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!sync[i])
          sat_cnt[i] <= '0;
        else if (tick && (sat_cnt[i] < SW'(PULSE_CNT_MAX)))
          sat_cnt[i] <= sat_cnt[i] + SW'(1);
      end
    end
  end

  always_comb begin
    level_w = '0;
    for (int i = 0; i < WIDTH; i++) level_w[i] = (sat_cnt[i] == SW'(PULSE_CNT_MAX));
  end

  assign rise = level_w & ~level_q;

`ifdef BUTTON_PARSER_REPEAT_EN
  localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

  logic [RW-1:0]    rep_cnt [WIDTH];
  logic [WIDTH-1:0] rep_fire;

  // Excluding the rise cycle keeps a repeat from ever landing on the press pulse.
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < WIDTH; i++)
      rep_fire[i] = tick && level_w[i] && level_q[i] && (rep_cnt[i] == RW'(REPEAT_TICKS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!level_w[i] || rise[i])
          rep_cnt[i] <= '0;
        else if (rep_fire[i])
          rep_cnt[i] <= '0;
        else if (tick)
          rep_cnt[i] <= rep_cnt[i] + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      out_q   <= '0;
    end else begin
      level_q <= level_w;
      out_q   <= rise | rep_fire;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      out_q   <= '0;
    end else begin
      level_q <= level_w;
      out_q   <= rise;
    end
  end
`endif

  assign bus.out   = out_q;
  assign bus.level = level_w;

endmodule

// File: doc/button_parser.md
# button_parser

Conditions raw, asynchronous push-button inputs into clean single-cycle event pulses and debounced levels. It contains a per-bit two-flop synchronizer, a shared sample-tick generator, per-bit saturating debounce counters and a rising-edge detector. It sits between the board buttons and pulse-driven consumers such as the LED counter. Its `out` pulses drive those consumers' `ce`-style enables.

## Interface
- `WIDTH`, 4: number of independent button channels.
- `SAMPLE_CNT_MAX`, 62500: clock cycles per sample tick (500 µs at the 8 ns clock).
- `PULSE_CNT_MAX`, 200: consecutive high ticks required to declare a press (100 ms).
- `REPEAT_TICKS`, 500: ticks between auto-repeat pulses. Used only with `BUTTON_PARSER_REPEAT_EN`.

Ports:
- `clk`  in  1  system clock, 125 MHz, all state on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in`  in  WIDTH  raw button levels, asynchronous to `clk`, active-high.
- `out`  out  WIDTH  registered one-cycle press pulse per channel.
- `level`  out  WIDTH  debounced level per channel.

## Operation
- Reset (`rst_n`=0, asynchronous) clears every register:
  - both synchronizer stages, `sample_cnt`, all `sat_cnt`, `level`, the edge history, `out` and the repeat counters are 0.
  - Hence `out`=0 and `level`=0 during and immediately after reset.
- Synchronizer: `in[i]` passes through two flops and becomes `sync[i]`. `sync` is used only after the second stage.
- Sample tick:
  - `sample_cnt` has width $clog2(SAMPLE_CNT_MAX).
  - It counts 0..SAMPLE_CNT_MAX-1 every cycle and wraps to 0.
  - `tick`=1 combinationally in the cycle where `sample_cnt`==SAMPLE_CNT_MAX-1, so there is exactly one tick per SAMPLE_CNT_MAX cycles.
- Debounce counter `sat_cnt[i]`, width $clog2(PULSE_CNT_MAX+1):
  - If `sync[i]`==0, the counter clears to 0 at the next edge, regardless of `tick`.
  - If `sync[i]`==1 and `tick` and `sat_cnt[i]`<PULSE_CNT_MAX, it increments.
  - Otherwise it holds. It saturates at PULSE_CNT_MAX and never wraps.
- `level[i]` = (`sat_cnt[i]`==PULSE_CNT_MAX). It is decoded from the register.
- Edge detector:
  - `level_q[i]` holds `level[i]` delayed one cycle.
  - `out[i]` <= `level[i]` & ~`level_q[i]`, so there is exactly one pulse per debounced rising edge.
  - Release of a button produces no pulse.
- Channels are fully independent. Simultaneous presses on several bits give simultaneous pulses.
- A glitch shorter than one sample tick while `sat_cnt` is saturated clears `sat_cnt` and drops `level`. The re-press then yields a new pulse after the full debounce latency. This behaviour is intended.

## Timing
- Synchronizer latency is 2 edges.
- Press latency, for `in[i]` rising before edge 1 and held stable:
  - `out[i]` is high in the cycle after edge N, where (PULSE_CNT_MAX-1)·SAMPLE_CNT_MAX+4 ≤ N ≤ PULSE_CNT_MAX·SAMPLE_CNT_MAX+3.
  - The exact N depends on tick phase.
- The `out` pulse width is exactly 1 cycle.
- `level` leads `out` by 1 cycle.
- Release latency: `level[i]` falls 3 edges after `in[i]` falls (2 synchronizer edges plus the clear edge).
- Reset mid-press: all state clears. A button still held when `rst_n` rises produces a fresh pulse after the full press latency measured from reset release.
- Bounds: PULSE_CNT_MAX ≥ 1 and SAMPLE_CNT_MAX ≥ 2. Counter widths must hold their maximum values exactly.

## Configuration
- Macro `BUTTON_PARSER_REPEAT_EN`.
- Defined: adds per-channel `rep_cnt[i]`, width $clog2(REPEAT_TICKS).
  - Cleared while `level[i]`==0 and in the cycle `level[i]` rises.
  - Increments on `tick` while `level[i]`==1.
  - When `tick` and `rep_cnt[i]`==REPEAT_TICKS-1: `rep_cnt[i]` wraps to 0 and `out[i]` pulses for one cycle at the next edge, ORed with the edge pulse.
  - The result is repeat pulses every REPEAT_TICKS·SAMPLE_CNT_MAX cycles while the button is held.
  - The first repeat pulse follows the press pulse by REPEAT_TICKS ticks, so the two never coincide.
- Undefined: no repeat logic. `out` pulses only on debounced rising edges.

## Test plan
Bench parameters: WIDTH=4, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, REPEAT_TICKS=5.
- Reset: hold `rst_n`=0 with `in`=4'hF for 20 cycles, then release. `out`=0 and `level`=0 throughout reset. One pulse per bit appears between 12 and 15 edges after release.
- Clean press: raise `in[0]` and hold it. `out[0]` is high for exactly 1 cycle, between edges 12 and 15. `level[0]` stays 1. No further pulses (repeat off).
- Bounce: toggle `in[1]` every 3 cycles for 40 cycles, then hold it high. No pulse during bouncing. Exactly one pulse follows within 15 edges of the final rise.
- Release/re-press: after a press, drop `in[2]` for 1 cycle. `level[2]` falls 3 edges later. The re-held button gives a second single pulse.
- Simultaneous: raise `in`=4'b1010 on the same cycle. `out` equals 4'b1010 in a single cycle and is 0 otherwise.
- Repeat (`BUTTON_PARSER_REPEAT_EN` defined): hold `in[3]` for 100 cycles. There is an initial pulse, then pulses every 20 cycles. All pulses stop within 3 edges of release.
